resp_capture: RTL and testbench



---
 rtl/resp_capture_if.sv | 27 ++
 rtl/resp_capture.sv | 115 +++++++++++
 tb/tb_resp_capture.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/resp_capture_if.sv
// Bus bundle between the response-capture stage and whoever drives it:
// session control and serial response in, status and result words out.
interface resp_capture_if #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned SIG_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             y_in;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [LEN_W-1:0] ones_cnt;
    logic [7:0]       last_bits;

    // Stimulus side (bench or controller)
    modport master (
        output start, len, y_in,
        input  busy, done, signature, ones_cnt, last_bits
    );

    // Capture block side
    modport slave (
        input  start, len, y_in,
        output busy, done, signature, ones_cnt, last_bits
    );
endinterface

// File: rtl/resp_capture.sv
// Response capture: after a start, discards SKIP pipeline cycles, then folds
// len serial samples of y_in into an LFSR signature while counting ones and
// keeping a window of the most recent 8 bits. Results hold in DONE.
module resp_capture #(
    parameter int unsigned      LEN_W = 8,
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
    parameter int unsigned      SKIP  = 2
) (
    input logic           clk,
    input logic           rst,
    resp_capture_if.slave bus
);
    localparam int unsigned      SKIP_W    = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSkip    = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [LEN_W-1:0]  remain_q, remain_d;   // samples still to take
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [LEN_W-1:0]  ones_q, ones_d;
    logic [7:0]        last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fb;

    // Next-state: session control, skip countdown and per-sample compression
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        remain_d   = remain_q;
        sig_d      = sig_q;
        ones_d     = ones_q;
        last_d     = last_q;
        fb         = sig_q[SIG_W-1] ^ bus.y_in;

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    remain_d = bus.len;
                    sig_d    = SEED;
                    ones_d   = '0;
                    last_d   = '0;
                    if (SKIP > 0) begin
                        state_d    = StSkip;
                        skip_cnt_d = SKIP_INIT;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StSkip: begin
                // y_in is still carrying stale data from the upstream pipeline
                skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                if (skip_cnt_q == SKIP_W'(1)) begin
                    state_d = (remain_q == '0) ? StDone : StCapture;
                end
            end
            StCapture: begin
                // remain_q can only be zero here when SKIP is 0 and len was 0
                if (remain_q == '0) begin
                    state_d = StDone;
                end else begin
                    sig_d    = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                    ones_d   = ones_q + LEN_W'(bus.y_in);
                    last_d   = {last_q[6:0], bus.y_in};
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Status flags are registered copies of the decoded next state
        busy_d = (state_d == StSkip) || (state_d == StCapture);
        done_d = (state_d == StDone);
    end

    // State and result registers; rst aborts any session and wins over start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            skip_cnt_q <= '0;
            remain_q   <= '0;
            sig_q      <= SEED;
            ones_q     <= '0;
            last_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            remain_q   <= remain_d;
            sig_q      <= sig_d;
            ones_q     <= ones_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = sig_q;
    assign bus.ones_cnt  = ones_q;
    assign bus.last_bits = last_q;
endmodule

// File: tb/tb_resp_capture.sv
// Directed bench for resp_capture: a table of capture sessions with
// hand-computed signatures plus short sequences for restart, abort and
// start/rst collisions.
module tb_resp_capture;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    resp_capture_if #(.LEN_W(8), .SIG_W(16)) bus ();

    resp_capture #(
        .LEN_W(8),
        .SIG_W(16),
        .POLY (16'h1021),
        .SEED (16'hFFFF),
        .SKIP (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0]  len;
        logic [15:0] pat;     // bit j is the value of sample j
        logic [1:0]  junk;    // y_in driven during the two skip cycles
        logic [15:0] exp_sig;
        logic [7:0]  exp_ones;
        logic [7:0]  exp_last;
        int          exp_cyc; // edges from accepting start until done=1
    } vec_t;

    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a session, feed junk during skip then pat, wait (bounded) for done.
    // mid_start>0 pulses start (len=5) before that edge number after acceptance.
    task automatic run_session(input logic [7:0] l, input logic [15:0] pat,
                               input logic [1:0] junk, input int mid_start,
                               output int cyc, output int busy_cnt);
        bus.start = 1'b1;
        bus.len   = l;
        bus.y_in  = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.len   = 8'd3;
        cyc       = 0;
        busy_cnt  = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            int c;
            c = cyc + 1;
            if (bus.busy === 1'b1) busy_cnt++;
            if (c <= 2) bus.y_in = junk[c-1];
            else if (c - 3 < 16) bus.y_in = pat[c-3];
            else bus.y_in = 1'b1;
            if (mid_start > 0 && c == mid_start) begin
                bus.start = 1'b1;
                bus.len   = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int cyc;
        int bc;

        vecs[0] = '{8'd1, 16'h0000, 2'b11, 16'hEFDF, 8'd0, 8'h00, 3};
        vecs[1] = '{8'd1, 16'h0001, 2'b00, 16'hFFFE, 8'd1, 8'h01, 3};
        vecs[2] = '{8'd2, 16'h0003, 2'b00, 16'hFFFC, 8'd2, 8'h03, 4};
        vecs[3] = '{8'd2, 16'h0003, 2'b10, 16'hFFFC, 8'd2, 8'h03, 4};
        vecs[4] = '{8'd0, 16'hFFFF, 2'b11, 16'hFFFF, 8'd0, 8'h00, 2};
        vecs[5] = '{8'd3, 16'h0005, 2'b01, 16'hDFBA, 8'd2, 8'h05, 5};
        vecs[6] = '{8'd4, 16'h0000, 2'b11, 16'h0E1F, 8'd0, 8'h00, 6};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.len   = 8'd0;
        bus.y_in  = 1'b0;
        tick();
        tick();
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_sig", bus.signature, 16'hFFFF);
        check("reset_ones", bus.ones_cnt, 8'd0);
        check("reset_last", bus.last_bits, 8'h00);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_session(vecs[i].len, vecs[i].pat, vecs[i].junk, 0, cyc, bc);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].exp_cyc);
            check($sformatf("vec%0d_busy_at_done", i), bus.busy, 1'b0);
            check($sformatf("vec%0d_sig", i), bus.signature, vecs[i].exp_sig);
            check($sformatf("vec%0d_ones", i), bus.ones_cnt, vecs[i].exp_ones);
            check($sformatf("vec%0d_last", i), bus.last_bits, vecs[i].exp_last);
            tick();
        end

        // len=10 of all ones with a start pulse at sample 3 that must be ignored
        run_session(8'd10, 16'hFFFF, 2'b01, 5, cyc, bc);
        check("ign_cycles", cyc, 12);
        check("ign_sig", bus.signature, 16'hFC00);
        check("ign_ones", bus.ones_cnt, 8'd10);
        check("ign_last", bus.last_bits, 8'hFF);
        tick();
        tick();
        check("hold_done", bus.done, 1'b1);
        check("hold_sig", bus.signature, 16'hFC00);

        // Restart from DONE: reseed and drop done on the accepting edge
        bus.start = 1'b1;
        bus.len   = 8'd1;
        bus.y_in  = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_done", bus.done, 1'b0);
        check("restart_busy", bus.busy, 1'b1);
        check("restart_sig", bus.signature, 16'hFFFF);
        check("restart_ones", bus.ones_cnt, 8'd0);
        check("restart_last", bus.last_bits, 8'h00);
        tick();
        tick();
        tick();
        check("restart_fin_done", bus.done, 1'b1);
        check("restart_fin_sig", bus.signature, 16'hFFFE);
        tick();

        // Abort with rst on the edge of sample 3 of 10
        bus.start = 1'b1;
        bus.len   = 8'd10;
        tick();
        bus.start = 1'b0;
        bus.y_in  = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("pre_abort_ones", bus.ones_cnt, 8'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_sig", bus.signature, 16'hFFFF);
        check("abort_ones", bus.ones_cnt, 8'd0);
        check("abort_last", bus.last_bits, 8'h00);
        tick();
        tick();
        check("abort_idle_busy", bus.busy, 1'b0);
        check("abort_idle_done", bus.done, 1'b0);
        run_session(8'd2, 16'h0003, 2'b00, 0, cyc, bc);
        check("fresh_cycles", cyc, 4);
        check("fresh_sig", bus.signature, 16'hFFFC);
        check("fresh_ones", bus.ones_cnt, 8'd2);
        check("fresh_last", bus.last_bits, 8'h03);
        tick();

        // start and rst on the same edge: no session may begin
        bus.start = 1'b1;
        bus.len   = 8'd1;
        rst       = 1'b1;
        tick();
        bus.start = 1'b0;
        rst       = 1'b0;
        check("collide_busy", bus.busy, 1'b0);
        check("collide_sig", bus.signature, 16'hFFFF);
        tick();
        tick();
        check("collide_idle_busy", bus.busy, 1'b0);
        check("collide_idle_done", bus.done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
